// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM encoding, special
// scan-code values and default timing constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] BREAK_CODE    = 8'hF0;
  localparam logic [7:0] EXTENDED_CODE = 8'hE0;

  localparam int FILTER_LEN_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample level filter for the
// PS/2 clock line; emits a one-cycle pulse on each accepted falling edge.
module ps2_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic raw,
  output logic filt_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          filt;

  // cnt counts samples that disagree with filt; the FILTER_LEN-th flips it
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      cnt       <= '0;
      filt      <= 1'b1;
      filt_fall <= 1'b0;
    end else begin
      sync      <= {sync[0], raw};
      filt_fall <= 1'b0;
      if (sync[1] != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt      <= sync[1];
          cnt       <= '0;
          filt_fall <= filt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB-first, parity, stop.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data 0 on a filtered falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit, then publish or discard
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        PS2Clk,
  input  logic        PS2Data,
  output logic [15:0] keycode,
  output logic        oflag,
  output logic        rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e    state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [TW-1:0] tout_cnt;
  logic [1:0]    data_sync;
  logic          data_s;
  logic          clk_fall;
  logic          timeout;
  logic          frame_ok;
  logic          publish;
  logic          err;

  ps2_glitch_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk_50MHz(clk_50MHz),
    .rst_n    (rst_n),
    .raw      (PS2Clk),
    .filt_fall(clk_fall)
  );

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) data_sync <= 2'b11;
    else        data_sync <= {data_sync[0], PS2Data};
  end

  assign data_s = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_nxt;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= par_nxt;
  end

  assign frame_ok = ^{shift, par};
`else
  assign frame_ok = 1'b1;
`endif

  // An edge in the same cycle as expiry wins: the frame keeps going.
  assign timeout = (state != ST_IDLE) && (tout_cnt == TW'(TIMEOUT_CYC)) && !clk_fall;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n)                             tout_cnt <= '0;
    else if (state == ST_IDLE || clk_fall)  tout_cnt <= '0;
    else if (!timeout)                      tout_cnt <= tout_cnt + 1'b1;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
`ifdef PS2_PARITY_CHECK_EN
    par_nxt     = par;
`endif
    publish     = 1'b0;
    err         = 1'b0;
    if (clk_fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_nxt   = data_s;
`endif
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && frame_ok) publish = 1'b1;
          else                    err     = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
      err       = 1'b1;
    end
  end

  // publish and err come from exclusive branches, so the pulses never overlap
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      keycode <= '0;
      oflag   <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      oflag  <= publish;
      rx_err <= err;
      if (publish) keycode <= {keycode[7:0], shift};
    end
  end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, meaning: consecutive identical samples needed to accept a PS2Clk level change.
REQ-002 Parameter TIMEOUT_CYC, default 50000, meaning: clk_50MHz cycles (1 ms) allowed between PS2Clk falling edges inside a frame.
REQ-003 clk_50MHz  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PS2Clk  input  1  raw keyboard clock, asynchronous.
REQ-006 PS2Data  input  1  raw keyboard data, asynchronous.
REQ-007 keycode  output  16  [7:0] newest received byte, [15:8] previous byte.
REQ-008 oflag  output  1  one-cycle pulse when keycode is updated.
REQ-009 rx_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-010 PS2Clk and PS2Data SHALL each pass through a 2-flop synchronizer before any use.
REQ-011 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; it resets to 1.
REQ-012 A falling edge of the filtered clock SHALL be the only event that samples synchronized PS2Data.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-014 IDLE: edge with data 0 (start bit) -> DATA with bit counter 0; edge with data 1 ignored, stays IDLE.
REQ-015 DATA: each edge shifts data into the byte LSB-first; counter 3 bits; after the 8th bit -> PARITY.
REQ-016 PARITY: edge stores the parity bit -> STOP.
REQ-017 STOP: edge with data 1 and valid frame -> publish, IDLE; otherwise rx_err pulse, keycode unchanged, IDLE.
REQ-018 Publish SHALL load keycode <= {keycode[7:0], byte} and pulse oflag exactly one cycle, one clk_50MHz cycle after the stop-bit edge is detected.
REQ-019 Timeout counter SHALL clear on every filtered falling edge and in IDLE; if it reaches TIMEOUT_CYC outside IDLE the FSM SHALL go to IDLE, pulse rx_err, and not publish.
REQ-020 Edge and timeout in the same cycle: edge SHALL win, counter clears.
REQ-021 Byte values 0xF0 and 0xE0 SHALL be published like any other byte; no break/extended interpretation here.
REQ-022 oflag and rx_err SHALL never be asserted in the same cycle.

Reset
REQ-023 rst_n low SHALL immediately force: keycode 0, oflag 0, rx_err 0, FSM IDLE, bit counter 0, timeout counter 0, filter counter 0, filtered clock 1, synchronizers 1.
REQ-024 Reset mid-frame SHALL abandon the frame; the first frame after release SHALL start only on a new start bit.

Configuration
REQ-025 Macro PS2_PARITY_CHECK_EN defined: frame valid only if XOR of 8 data bits and parity bit is 1 (odd parity); odd-parity failure -> rx_err, no publish.
REQ-026 Macro PS2_PARITY_CHECK_EN undefined: parity bit sampled and ignored; validity depends only on stop bit = 1.

Structure
REQ-027 Package ps2_pkg SHALL hold the FSM state encoding, BREAK_CODE 8'hF0, EXTENDED_CODE 8'hE0 and the default FILTER_LEN/TIMEOUT_CYC constants.
REQ-028 Synchronizer plus FILTER_LEN filter SHALL be sub-module ps2_glitch_filter, instantiated for PS2Clk.

Verification
REQ-029 Frame 0x1C, correct odd parity, stop 1 -> keycode 0x001C, one oflag pulse, rx_err 0.
REQ-030 Frames 0xF0 then 0x1C -> keycode 0xF01C after second oflag; two oflag pulses total.
REQ-031 With PS2_PARITY_CHECK_EN, frame 0x23 with wrong parity -> rx_err one pulse, keycode unchanged; without macro -> keycode low byte 0x23, oflag.
REQ-032 PS2Clk glitch low for FILTER_LEN-1 cycles during IDLE and mid-DATA -> no bit sampled, subsequent frame 0x74 received correctly.
REQ-033 Frame stopped after 4 data bits, clock held high 1.2 ms -> rx_err at TIMEOUT_CYC, FSM IDLE, next frame 0x6B received as keycode low byte 0x6B.
REQ-034 rst_n pulsed low during DATA of frame 0x75 -> all outputs 0, no oflag; next full frame 0x72 -> keycode 0x0072.
